program_memory_loader: RTL and testbench

Writer side of the instruction memory: receives a byte stream from the UART receiver over a valid/ready handshake. Assembles little-endian 32-bit instructions and writes them into the program RAM at consecutive word addresses starting at 0. Holds the RISC-V core stalled while loading, so a new program can be downloaded without resynthesis. The existing program memory is then read combinationally by the core, word-addressed.

---
 rtl/program_memory_loader.sv | 136 +++++++++++++
 tb/tb_program_memory_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_memory_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// program_memory_loader
//
// Writer side of the instruction memory. It takes a byte stream from the UART
// receiver over a valid/ready handshake. The stream is a 16-bit little-endian
// word count, followed by that many little-endian 32-bit instructions. Each
// instruction is written to the program RAM at consecutive word addresses,
// starting at 0. While a load is in progress, the RISC-V core is held.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   start          single-cycle pulse; begins a load when not busy
//   rx_data        byte from UART receiver
//   rx_valid       rx_data valid
//   rx_ready       loader accepts a byte this cycle (state decode only)
//   mem_we         program RAM write enable, one cycle per word
//   mem_address    word address of the current/last write
//   mem_write_data assembled instruction of the current/last write
//   words_loaded   words written in the current/last load
//   busy           load in progress
//   cpu_hold       equals busy; stalls the core
//   done           sticky: load finished successfully
//   error          sticky: length header exceeded MEMORY_DEPTH
// -----------------------------------------------------------------------------
module program_memory_loader #(
  parameter int MEMORY_DEPTH = 128,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [15:0]           words_loaded,
  output logic                  busy,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR
  } state_t;

  localparam logic [15:0] DEPTH16 = 16'(MEMORY_DEPTH);

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [15:0] length;
  logic [23:0] lo_bytes;   // first three bytes of the word, byte 0 in [7:0]
  logic [15:0] len_full;
  logic [15:0] words_next;

  // The full length is compared in the cycle the high byte arrives.
  assign len_full   = {rx_data, length[7:0]};
  assign words_next = words_loaded + 16'd1;

  // All handshake and status outputs decode only the state register. This
  // keeps rx_ready free of any combinational path from rx_valid.
  assign rx_ready = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
  assign mem_we   = (state == WRITE);
  assign busy     = (state == LEN_LO) || (state == LEN_HI) ||
                    (state == DATA)   || (state == WRITE);
  assign cpu_hold = busy;

  // NOTE: every register in this block uses <=. All of them then sample the
  // values from before the edge, which matches real flops regardless of the
  // order in which the statements are written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      byte_cnt       <= 2'd0;
      length         <= 16'd0;
      lo_bytes       <= 24'd0;
      words_loaded   <= 16'd0;
      mem_address    <= '0;
      mem_write_data <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          // The sticky flags go high one cycle after the terminal state is
          // entered. As a result, done follows the final write by two edges.
          if (state == DONE)  done  <= 1'b1;
          if (state == ERROR) error <= 1'b1;
          if (start) begin
            state        <= LEN_LO;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 16'd0;
            byte_cnt     <= 2'd0;
          end
        end
        // In the states below, rx_ready is 1, so rx_valid alone marks a transfer.
        LEN_LO: if (rx_valid) begin
          length[7:0] <= rx_data;
          state       <= LEN_HI;
        end
        LEN_HI: if (rx_valid) begin
          length[15:8] <= rx_data;
          if (len_full == 16'd0)         state <= DONE;
          else if (len_full > DEPTH16)   state <= ERROR;
          else                           state <= DATA;
        end
        DATA: if (rx_valid) begin
          if (byte_cnt == 2'd3) begin
            // The write port registers are captured here and then hold their
            // values until the next word.
            mem_write_data <= {rx_data, lo_bytes};
            mem_address    <= words_loaded[ADDR_WIDTH-1:0];
            byte_cnt       <= 2'd0;
            state          <= WRITE;
          end else begin
            lo_bytes <= {rx_data, lo_bytes[23:8]};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        WRITE: begin
          words_loaded <= words_next;
          byte_cnt     <= 2'd0;
          state        <= (words_next == length) ? DONE : DATA;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_memory_loader.sv
`timescale 1ns/1ps
module tb_program_memory_loader;

  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, mem_we, busy, cpu_hold, done, error;
  logic [6:0]  mem_address;
  logic [31:0] mem_write_data;
  logic [15:0] words_loaded;

  int total = 0;
  int bad   = 0;

  logic [31:0] words [0:DEPTH-1];   // the program being downloaded
  logic [6:0]  cap_addr [$];        // observed RAM writes
  logic [31:0] cap_data [$];

  program_memory_loader #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32), .ADDR_WIDTH(7)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .mem_we(mem_we),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .words_loaded(words_loaded), .busy(busy), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Record every RAM write, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      cap_addr.push_back(mem_address);
      cap_data.push_back(mem_write_data);
    end
  end

  // Offer one byte after a random idle gap. Hold it until the loader takes it.
  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int g;
    int n;
    g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    repeat (g) begin @(negedge clk); rx_valid = 1'b0; end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (rx_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    total++;
    if (n >= 40) begin bad++; $display("FAIL rx_ready_timeout byte=%h", b); end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic clear_caps();
    cap_addr.delete();
    cap_data.delete();
  endtask

  // Reset in the middle of a cycle. All outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({rx_ready, mem_we, mem_address, mem_write_data, words_loaded,
         busy, cpu_hold, done, error} !== '0) begin
      bad++;
      $display("FAIL %s_outputs_zero we=%b addr=%0d data=%h wl=%0d busy=%b hold=%b done=%b err=%b rdy=%b",
               tag, mem_we, mem_address, mem_write_data, words_loaded, busy, cpu_hold, done, error, rx_ready);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Download the first len entries of words[] behind a length header. The
  // results are then checked against the loader's rules: 1..DEPTH words are
  // written in order from address 0; 0 means done with no writes; larger
  // values raise an error and no data is sent.
  task automatic load_and_check(input int len, input int gap, input string tag);
    int exp_n;
    int n;
    logic [15:0] l16;
    logic [31:0] w;
    l16   = 16'(len);
    exp_n = (len >= 1 && len <= DEPTH) ? len : 0;
    clear_caps();
    pulse_start();
    send_byte(l16[7:0], gap);
    send_byte(l16[15:8], gap);
    for (int i = 0; i < exp_n; i++) begin
      w = words[i];
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    end
    n = 0;
    while (done !== 1'b1 && error !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (n >= 20) begin bad++; $display("FAIL %s_finish_timeout", tag); end
    total++;
    if (done !== (len <= DEPTH)) begin
      bad++; $display("FAIL %s_done got=%b want=%b", tag, done, (len <= DEPTH));
    end
    total++;
    if (error !== (len > DEPTH)) begin
      bad++; $display("FAIL %s_error got=%b want=%b", tag, error, (len > DEPTH));
    end
    total++;
    if (words_loaded !== 16'(exp_n)) begin
      bad++; $display("FAIL %s_words_loaded got=%0d want=%0d", tag, words_loaded, exp_n);
    end
    total++;
    if ({busy, cpu_hold, rx_ready, mem_we} !== 4'b0000) begin
      bad++; $display("FAIL %s_idle_flags got busy=%b hold=%b rdy=%b we=%b want 0", tag, busy, cpu_hold, rx_ready, mem_we);
    end
    total++;
    if (cap_addr.size() !== exp_n) begin
      bad++; $display("FAIL %s_write_count got=%0d want=%0d", tag, cap_addr.size(), exp_n);
    end else begin
      for (int i = 0; i < exp_n; i++) begin
        total++;
        if (cap_addr[i] !== 7'(i) || cap_data[i] !== words[i]) begin
          bad++;
          $display("FAIL %s_write%0d got addr=%0d data=%h want addr=%0d data=%h",
                   tag, i, cap_addr[i], cap_data[i], i, words[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({rx_ready, mem_we, mem_address, mem_write_data, words_loaded,
         busy, cpu_hold, done, error} !== '0) begin
      bad++; $display("FAIL reset_outputs got nonzero we=%b busy=%b done=%b err=%b", mem_we, busy, done, error);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, rx_ready, done, error} !== 4'b0000) begin
      bad++; $display("FAIL reset_idle got busy=%b rdy=%b done=%b err=%b", busy, rx_ready, done, error);
    end
  endtask

  // A single word with exact cycle timing around the write and done.
  task automatic test_single_word();
    clear_caps();
    pulse_start();
    total++;
    if ({busy, cpu_hold, rx_ready} !== 3'b111) begin
      bad++; $display("FAIL single_busy got busy=%b hold=%b rdy=%b want 111", busy, cpu_hold, rx_ready);
    end
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h13, 0); send_byte(8'h05, 0); send_byte(8'hA0, 0); send_byte(8'h00, 0);
    @(negedge clk);   // cycle N..N+1
    total++;
    if (mem_we !== 1'b1 || mem_address !== 7'd0 || mem_write_data !== 32'h00A00513 || rx_ready !== 1'b0) begin
      bad++; $display("FAIL single_write got we=%b addr=%0d data=%h rdy=%b want 1 0 00a00513 0",
                      mem_we, mem_address, mem_write_data, rx_ready);
    end
    @(negedge clk);   // cycle N+1..N+2
    total++;
    if (mem_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || words_loaded !== 16'd1) begin
      bad++; $display("FAIL single_after_write got we=%b done=%b busy=%b wl=%0d want 0 0 0 1",
                      mem_we, done, busy, words_loaded);
    end
    @(negedge clk);   // after edge N+2
    total++;
    if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0) begin
      bad++; $display("FAIL single_done got done=%b err=%b hold=%b want 1 0 0", done, error, cpu_hold);
    end
    total++;
    if (mem_address !== 7'd0 || mem_write_data !== 32'h00A00513 || cap_addr.size() !== 1) begin
      bad++; $display("FAIL single_hold got addr=%0d data=%h writes=%0d want 0 00a00513 1",
                      mem_address, mem_write_data, cap_addr.size());
    end
  endtask

  task automatic test_gaps();
    words[0] = 32'h11111111; words[1] = 32'h22222222; words[2] = 32'h33333333;
    load_and_check(3, 4, "gaps");
    for (int i = 0; i < 10; i++) words[i] = $urandom;
    load_and_check(int'($urandom_range(10, 4)), 3, "random");
  endtask

  task automatic test_len_zero();
    load_and_check(0, 0, "len0");
  endtask

  task automatic test_len_over();
    load_and_check(DEPTH + 1, 0, "len129");
    pulse_start();
    total++;
    if (error !== 1'b0 || busy !== 1'b1 || rx_ready !== 1'b1) begin
      bad++; $display("FAIL restart_clears_error got err=%b busy=%b rdy=%b want 0 1 1", error, busy, rx_ready);
    end
    do_reset("err_abort");
  endtask

  task automatic test_full_depth();
    for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
    load_and_check(DEPTH, 0, "full");
    total++;
    if (mem_address !== 7'd127) begin
      bad++; $display("FAIL full_last_addr got=%0d want=127", mem_address);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] w;
    for (int i = 0; i < 5; i++) words[i] = $urandom;
    clear_caps();
    pulse_start();
    send_byte(8'd5, 0); send_byte(8'd0, 0);
    w = words[0];
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1);
    pulse_start();    // must be ignored while busy
    w = words[1];
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1);
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b1 || words_loaded !== 16'd2 || cap_addr.size() !== 2) begin
      bad++; $display("FAIL midload_progress got busy=%b wl=%0d writes=%0d want 1 2 2",
                      busy, words_loaded, cap_addr.size());
    end else begin
      total++;
      if (cap_addr[0] !== 7'd0 || cap_data[0] !== words[0] ||
          cap_addr[1] !== 7'd1 || cap_data[1] !== words[1]) begin
        bad++; $display("FAIL midload_writes got %0d:%h %0d:%h want 0:%h 1:%h",
                        cap_addr[0], cap_data[0], cap_addr[1], cap_data[1], words[0], words[1]);
      end
    end
    do_reset("midload");
    words[0] = $urandom;
    load_and_check(1, 1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_gaps();
    test_len_zero();
    test_len_over();
    test_full_depth();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute bound so the run always terminates.
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
